// File: rtl/slot_game_fsm_pkg.sv
// slot_game_fsm_pkg: shared state enumeration, display letter codes and result decoder.
package slot_game_fsm_pkg;

    typedef enum logic [1:0] {SPIN, JUDGE, RESULT} state_e;

    localparam logic [4:0] LTR_G = 5'h10;
    localparam logic [4:0] LTR_O = 5'h11;
    localparam logic [4:0] LTR_D = 5'h12;
    localparam logic [4:0] LTR_L = 5'h13;
    localparam logic [4:0] LTR_S = 5'h14;
    localparam logic [4:0] LTR_E = 5'h15;

    // Packed as {message3, message2, message1, message0}.
    function automatic logic [19:0] result_msg(input logic win);
        return win ? {LTR_D, LTR_O, LTR_O, LTR_G} : {LTR_E, LTR_S, LTR_O, LTR_L};
    endfunction

endpackage

// File: rtl/slot_game_fsm_key_edge_detect.sv
// key_edge_detect: per-bit rising-edge detector against a registered previous sample.
module key_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= '0;
        else          prev_q <= in;
    end

    assign rise = in & ~prev_q;

endmodule

// File: rtl/slot_game_fsm.sv
// slot_game_fsm: four-reel slot round controller -- freeze reels on key edges,
// judge latched letters, then hold a GOOD/LOSE display for 2^en_width cycles.
module slot_game_fsm
    import slot_game_fsm_pkg::*;
#(
    parameter int en_width = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key,
    input  logic [3:0] letter0,
    input  logic [3:0] letter1,
    input  logic [3:0] letter2,
    input  logic [3:0] letter3,
    output logic [3:0] stop_flag,
    output logic [4:0] message0,
    output logic [4:0] message1,
    output logic [4:0] message2,
    output logic [4:0] message3,
    output logic       end_flag
);

    state_e              state_q, state_d;
    logic [3:0]          stop_q, stop_d;
    logic [15:0]         letters_q, letters_d;
    logic [en_width-1:0] cnt_q, cnt_d;
    logic [19:0]         msg_q, msg_d;
    logic                end_q, end_d;
    logic [3:0]          rise;
    logic                win;

    key_edge_detect #(.WIDTH(4)) u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (key),
        .rise    (rise)
    );

    always_comb begin
        state_d   = state_q;
        stop_d    = stop_q;
        letters_d = letters_q;
        cnt_d     = '0;
        case (state_q)
            SPIN: begin
                stop_d = stop_q & ~rise;
                if (stop_q == 4'h0) state_d = JUDGE;
            end
            JUDGE: begin
                letters_d = {letter3, letter2, letter1, letter0};
                state_d   = RESULT;
            end
            RESULT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = SPIN;
                    stop_d  = 4'hF;
                end
            end
            default: state_d = SPIN;
        endcase
        end_d = (state_d == RESULT);
        // Judged from letters_d so the display is valid on the first RESULT cycle.
        win   = (letters_d[3:0] == letters_d[7:4]) && (letters_d[3:0] == letters_d[11:8]) &&
                (letters_d[3:0] == letters_d[15:12]);
        msg_d = end_d ? result_msg(win) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SPIN;
            stop_q    <= 4'hF;
            letters_q <= '0;
            cnt_q     <= '0;
            msg_q     <= '0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            letters_q <= letters_d;
            cnt_q     <= cnt_d;
            msg_q     <= msg_d;
            end_q     <= end_d;
        end
    end

    assign stop_flag = stop_q;
    assign end_flag  = end_q;
    assign message0  = msg_q[4:0];
    assign message1  = msg_q[9:5];
    assign message2  = msg_q[14:10];
    assign message3  = msg_q[19:15];

endmodule

// File: tb/tb_slot_game_fsm.sv
// tb_slot_game_fsm: directed + randomized rounds checked against a round-level reference model.
module tb_slot_game_fsm;

    localparam int EW   = 3;
    localparam int HOLD = 1 << EW;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] key = 4'h0;
    logic [3:0] letter [4];
    logic [3:0] stop_flag;
    logic [4:0] message0, message1, message2, message3;
    logic       end_flag;

    int checks = 0;
    int errors = 0;

    // Reference model: round phase, frozen mask, result countdown, displayed letters.
    int         m_mode;
    int         m_left;
    logic [3:0] m_stop;
    logic [3:0] m_prev;
    logic       m_end;
    logic [4:0] m_msg [4];

    slot_game_fsm #(.en_width(EW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .letter0   (letter[0]),
        .letter1   (letter[1]),
        .letter2   (letter[2]),
        .letter3   (letter[3]),
        .stop_flag (stop_flag),
        .message0  (message0),
        .message1  (message1),
        .message2  (message2),
        .message3  (message3),
        .end_flag  (end_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_stop = 4'hF;
        m_prev = 4'h0;
        m_end  = 1'b0;
        for (int i = 0; i < 4; i++) m_msg[i] = 5'h00;
    endtask

    task automatic model_step();
        logic [3:0] r;
        logic       same;
        r      = key & ~m_prev;
        m_prev = key;
        if (m_mode == 0) begin
            if (m_stop == 4'h0) m_mode = 1;
            else m_stop = m_stop & ~r;
        end else if (m_mode == 1) begin
            same   = (letter[0] == letter[1]) && (letter[1] == letter[2]) && (letter[2] == letter[3]);
            m_mode = 2;
            m_left = HOLD;
            m_end  = 1'b1;
            if (same) begin
                m_msg[0] = 5'h10; m_msg[1] = 5'h11; m_msg[2] = 5'h11; m_msg[3] = 5'h12;
            end else begin
                m_msg[0] = 5'h13; m_msg[1] = 5'h11; m_msg[2] = 5'h14; m_msg[3] = 5'h15;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 0;
                m_stop = 4'hF;
                m_end  = 1'b0;
                for (int i = 0; i < 4; i++) m_msg[i] = 5'h00;
            end
        end
    endtask

    task automatic compare_all();
        check("stop_flag", 32'(stop_flag), 32'(m_stop));
        check("end_flag", 32'(end_flag), 32'(m_end));
        check("message0", 32'(message0), 32'(m_msg[0]));
        check("message1", 32'(message1), 32'(m_msg[1]));
        check("message2", 32'(message2), 32'(m_msg[2]));
        check("message3", 32'(message3), 32'(m_msg[3]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_letters(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        letter[0] = a; letter[1] = b; letter[2] = c; letter[3] = d;
    endtask

    task automatic freeze_all();
        key = 4'h0;
        tick();
        key = 4'hF;
        tick();
        key = 4'h0;
    endtask

    // Runs until the result display ends; letters are cleared once end_flag rises.
    task automatic finish_round(input logic check_hold);
        int  hold;
        bit  seen;
        bit  done;
        hold = 0;
        seen = 0;
        done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            tick();
            if (m_end) begin
                seen = 1;
                hold++;
                set_letters(4'h0, 4'h0, 4'h0, 4'h0);
            end else if (seen) done = 1;
        end
        check("round_done", 32'(done), 32'd1);
        if (check_hold) check("hold_len", 32'(hold), 32'(HOLD));
    endtask

    initial begin
        set_letters(4'h0, 4'h0, 4'h0, 4'h0);
        model_reset();
        pulse_reset();

        // Keys pressed one at a time, all letters equal.
        set_letters(4'h7, 4'h7, 4'h7, 4'h7);
        for (int i = 0; i < 4; i++) begin
            key = 4'(1 << i);
            tick();
            key = 4'h0;
            tick();
        end
        check("seq_all_frozen", 32'(stop_flag), 32'h0);
        finish_round(1'b1);
        check("seq_back_spin", 32'(stop_flag), 32'hF);

        // Simultaneous freeze, one mismatched letter.
        set_letters(4'h3, 4'h3, 4'h3, 4'h4);
        key = 4'hF;
        tick();
        check("simul_freeze", 32'(stop_flag), 32'h0);
        key = 4'h0;
        finish_round(1'b1);

        // Held key and repeated presses on a frozen reel.
        set_letters(4'h5, 4'h5, 4'h5, 4'h5);
        key = 4'h4;
        repeat (20) tick();
        for (int i = 0; i < 2; i++) begin
            key = 4'h0;
            tick();
            key = 4'h4;
            tick();
        end
        key = 4'h0;
        tick();
        check("held_key_once", 32'(stop_flag), 32'hB);
        key = 4'hB;
        tick();
        key = 4'h0;
        finish_round(1'b1);

        // Letters cleared when end_flag rises; judgment uses latched values.
        set_letters(4'h9, 4'h9, 4'h9, 4'h9);
        freeze_all();
        finish_round(1'b1);

        // Reset during the fourth RESULT cycle.
        set_letters(4'h2, 4'h2, 4'h2, 4'h2);
        freeze_all();
        for (int n = 0; n < 10 && !m_end; n++) tick();
        check("reached_result", 32'(end_flag), 32'd1);
        repeat (3) tick();
        pulse_reset();
        check("abort_end", 32'(end_flag), 32'd0);
        set_letters(4'h1, 4'h6, 4'h1, 4'h1);
        freeze_all();
        finish_round(1'b1);

        // Key held across RESULT-to-SPIN stays inert until re-pressed.
        set_letters(4'hA, 4'hA, 4'hA, 4'hA);
        freeze_all();
        for (int n = 0; n < 10 && !m_end; n++) tick();
        key = 4'h2;
        for (int n = 0; n < 20 && m_end; n++) tick();
        repeat (5) tick();
        check("held_across", 32'(stop_flag), 32'hF);
        key = 4'h0;
        tick();
        key = 4'h2;
        tick();
        check("repress", 32'(stop_flag), 32'hD);
        key = 4'h0;
        tick();

        // Key held through reset freezes on the first cycle after release.
        key = 4'h1;
        pulse_reset();
        tick();
        check("held_thru_reset", 32'(stop_flag), 32'hE);
        key = 4'h0;
        freeze_all();
        finish_round(1'b1);

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            int  n;
            bit  seen;
            bit  done;
            if ($urandom_range(2) == 0) begin
                letter[0] = 4'($urandom);
                for (int i = 1; i < 4; i++) letter[i] = letter[0];
            end else begin
                for (int i = 0; i < 4; i++) letter[i] = 4'($urandom);
            end
            seen = 0;
            done = 0;
            for (n = 0; n < 400 && !done; n++) begin
                key = 4'($urandom & $urandom);
                tick();
                if (m_end) seen = 1;
                else if (seen) done = 1;
            end
            check("rand_round_done", 32'(done), 32'd1);
        end

        key = 4'h0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_game_fsm.md
SLOT_GAME_FSM -- requirements
Module: slot_game_fsm

Interface
REQ-001 The block SHALL have parameter en_width, default 8, giving a result-display hold of 2^en_width clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port key, input, 4 bits, debounced buttons, 1 = pressed; key[i] owns reel i.
REQ-005 The block SHALL have ports letter0..letter3, input, 4 bits each, current reel values 0x0-0xF.
REQ-006 The block SHALL have port stop_flag, output, 4 bits; 1 = reel i spins, 0 = reel i frozen.
REQ-007 The block SHALL have ports message0..message3, output, 5 bits each, display codes for reels 0..3.
REQ-008 The block SHALL have port end_flag, output, 1 bit; 1 = result displayed, round over.

Function
REQ-009 The block SHALL implement states SPIN, JUDGE and RESULT, with SPIN entered from reset.
REQ-010 In SPIN, a rising edge on key[i] SHALL clear stop_flag[i] on the next clk edge; latency is 1 cycle from the first sample of key[i]=1 with the previous sample 0.
REQ-011 Edge detection SHALL use a per-bit registered previous sample that updates every cycle in every state.
REQ-012 A held key SHALL never generate a second edge.
REQ-013 Presses on already-frozen reels SHALL be ignored.
REQ-014 Simultaneous edges on several keys SHALL freeze all of those reels in the same cycle.
REQ-015 When stop_flag becomes 4'h0, the next cycle SHALL be JUDGE, lasting exactly 1 cycle.
REQ-016 In JUDGE, the block SHALL latch letter0..3 internally; downstream clears the letters when end_flag rises, so judgment must not use the live letter inputs afterwards.
REQ-017 On JUDGE exit, the block SHALL enter RESULT with end_flag=1.
REQ-018 On entering RESULT, message0..3 SHALL be G,O,O,D = 0x10,0x11,0x11,0x12 when all four latched letters are equal.
REQ-019 Otherwise, message0..3 SHALL be L,O,S,E = 0x13,0x11,0x14,0x15.
REQ-020 RESULT SHALL last exactly 2^en_width cycles, counted by an en_width-bit counter that is 0 on entry and exits on the all-ones value.
REQ-021 Keys SHALL be ignored during JUDGE and RESULT, although the previous samples keep updating.
REQ-022 On leaving RESULT, the next cycle SHALL be SPIN with stop_flag=4'hF, end_flag=0 and message0..3=0x00.
REQ-023 A key already held across the RESULT-to-SPIN boundary SHALL NOT freeze its reel.
REQ-024 Outside RESULT, message0..3 SHALL be 0x00.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Asserting reset_n=0 SHALL, immediately and asynchronously, set state=SPIN, stop_flag=4'hF, end_flag=0, message0..3=0x00, counter=0, latched letters=0 and previous key samples=4'h0.
REQ-027 Reset asserted mid-SPIN, mid-JUDGE or mid-RESULT SHALL abort the round; no result is shown after release.
REQ-028 The first cycle after reset_n release SHALL evaluate edges against previous samples of 0, so a key held through reset freezes its reel.

Structure
REQ-029 A shared package SHALL hold the state enumeration (SPIN, JUDGE, RESULT).
REQ-030 The shared package SHALL hold letter-code constants LTR_G=0x10, LTR_O=0x11, LTR_D=0x12, LTR_L=0x13, LTR_S=0x14 and LTR_E=0x15, which the display decoder also uses.
REQ-031 A single sub-module key_edge_detect (width parameter, clk, reset_n, in, rise) SHALL provide the edge detection.
REQ-032 The state machine, latch, counter and message logic SHALL stay in slot_game_fsm.

Verification (en_width=3 unless stated)
REQ-033 Reset, then keys 0,1,2,3 pressed in separate cycles with letters all 0x7 -> stop_flag steps F,E,C,8,0; JUDGE for 1 cycle; end_flag=1 with messages 10,11,11,12 for exactly 8 cycles; then stop_flag=F and end_flag=0.
REQ-034 Letters 0x3,0x3,0x3,0x4 with all four keys pressed in the same cycle -> stop_flag F to 0 in one cycle; messages 13,11,14,15.
REQ-035 key[2] held for 20 cycles and pressed twice more while frozen -> stop_flag[2] cleared once; other bits remain 1.
REQ-036 Letter inputs forced to 0 on the cycle end_flag rises -> messages still reflect the letters latched in JUDGE.
REQ-037 reset_n pulsed low during cycle 4 of RESULT -> end_flag=0, stop_flag=F and messages 0 asynchronously; normal SPIN after release.
REQ-038 key[1] held from RESULT into SPIN -> stop_flag[1] stays 1 until release followed by a new press.
